// File: rtl/key_expansion_inv_pkg.sv
// Shared AES key-schedule helpers: sizing, word type, RotWord, SubWord and Rcon.
package key_expansion_inv_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    StIdle,
    StAssemble,
    StPresent
  } state_e;

  // Number of rounds for a key of nk words.
  function automatic int unsigned num_rounds(input int unsigned nk);
    return nk + 6;
  endfunction

  // Number of 32-bit words in the full expanded schedule.
  function automatic int unsigned num_words(input int unsigned nk);
    return 4 * (nk + 7);
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, which maps 0 to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [5:0] idx);
    logic [7:0] rc;
    case (idx)
      6'd1:    rc = 8'h01;
      6'd2:    rc = 8'h02;
      6'd3:    rc = 8'h04;
      6'd4:    rc = 8'h08;
      6'd5:    rc = 8'h10;
      6'd6:    rc = 8'h20;
      6'd7:    rc = 8'h40;
      6'd8:    rc = 8'h80;
      6'd9:    rc = 8'h1b;
      6'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/key_expansion_inv_key_word_step.sv
// One backwards step of the key recurrence: w[i-nk] = w[i] ^ f(w[i-1]).
module key_expansion_inv_key_word_step
  import key_expansion_inv_pkg::*;
#(
  parameter int unsigned nk = 4
) (
  input  word_t      w_hi_i,    // w[i]
  input  word_t      w_prev_i,  // w[i-1]
  input  logic [5:0] idx_i,     // i
  output word_t      w_lo_o     // w[i-nk]
);

  localparam logic [5:0] NkW = 6'(nk);

  word_t      f;
  logic [5:0] phase;
  logic [5:0] rc_idx;

  // Select the schedule transform by the position of i within its nk-word group.
  always_comb begin
    phase  = idx_i % NkW;
    rc_idx = idx_i / NkW;
    f      = w_prev_i;
    if (phase == 6'd0) begin
      f = sub_word(rot_word(w_prev_i)) ^ {rcon(rc_idx), 24'h000000};
    end else if (nk == 8 && phase == 6'd4) begin
      f = sub_word(w_prev_i);
    end
    w_lo_o = w_hi_i ^ f;
  end

endmodule

// File: rtl/key_expansion_inv.sv
// Inverse AES key schedule: regenerates round keys Nr..0 from the final nk schedule words.
module key_expansion_inv
  import key_expansion_inv_pkg::*;
#(
  parameter int unsigned nk = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [32*nk-1:0] last_key,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    round_key,
  output logic [3:0]      round_idx,
  output logic            done
);

  localparam int unsigned W       = num_words(nk);
  localparam logic [5:0]  JLast   = 6'(W - 1);
  localparam logic [5:0]  KeyBase = 6'(W - nk);
  localparam logic [5:0]  NkW     = 6'(nk);

  if (!(nk == 4 || nk == 6 || nk == 8)) begin : g_nk_check
    $error("key_expansion_inv: nk must be 4, 6 or 8");
  end

  state_e         state_q, state_d;
  logic [5:0]     j_q, j_d;
  word_t          win_q [nk];  // win_q[k] holds w[j+1+k]
  word_t          win_d [nk];
  word_t          acc_q [1:3]; // acc_q[m] holds w[4r+m] while key r is assembled
  word_t          acc_d [1:3];
  logic [127:0]   round_key_q, round_key_d;
  logic [3:0]     round_idx_q, round_idx_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  word_t          step_word;
  word_t          cur_word;
  logic           from_key;

  key_expansion_inv_key_word_step #(
    .nk(nk)
  ) u_step (
    .w_hi_i   (win_q[nk-1]),
    .w_prev_i (win_q[nk-2]),
    .idx_i    (j_q + NkW),
    .w_lo_o   (step_word)
  );

  // Word w[j]: straight from the latched key for the top nk indices, else recomputed.
  always_comb begin
    from_key = (j_q >= KeyBase);
    cur_word = step_word;
    for (int unsigned k = 0; k < nk; k++) begin
      if (j_q == KeyBase + 6'(k)) cur_word = win_q[k];
    end
  end

  // Next-state and output logic for the IDLE/ASSEMBLE/PRESENT controller.
  always_comb begin
    state_d     = state_q;
    j_d         = j_q;
    win_d       = win_q;
    acc_d       = acc_q;
    round_key_d = round_key_q;
    round_idx_d = round_idx_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          for (int unsigned k = 0; k < nk; k++) begin
            win_d[k] = last_key[32*(nk-k)-1 -: 32];
          end
          j_d     = JLast;
          busy_d  = 1'b1;
          state_d = StAssemble;
        end
      end
      StAssemble: begin
        // The window only starts sliding once the latched words have been emitted.
        if (!from_key) begin
          for (int unsigned k = 1; k < nk; k++) win_d[k] = win_q[k-1];
          win_d[0] = cur_word;
        end
        unique case (j_q[1:0])
          2'd3: acc_d[3] = cur_word;
          2'd2: acc_d[2] = cur_word;
          2'd1: acc_d[1] = cur_word;
          default: begin
            round_key_d = {cur_word, acc_q[1], acc_q[2], acc_q[3]};
            round_idx_d = j_q[5:2];
            out_valid_d = 1'b1;
            state_d     = StPresent;
          end
        endcase
        if (j_q != 6'd0) j_d = j_q - 6'd1;
      end
      StPresent: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (round_idx_q == 4'd0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            state_d = StAssemble;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any run in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      j_q     <= '0;
      for (int unsigned k = 0; k < nk; k++) win_q[k] <= '0;
      acc_q[1]    <= '0;
      acc_q[2]    <= '0;
      acc_q[3]    <= '0;
      round_key_q <= '0;
      round_idx_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      win_q       <= win_d;
      acc_q       <= acc_d;
      round_key_q <= round_key_d;
      round_idx_q <= round_idx_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign round_key = round_key_q;
  assign round_idx = round_idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_key_expansion_inv.sv
// Bench for key_expansion_inv: spec vectors, forward-expansion scoreboard, corner sequences.
module tb_key_expansion_inv;

  localparam logic [255:0] V1  = 256'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [255:0] K0A = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] V2  = 256'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [255:0] K0B = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] V8  =
    256'h4e5a6699a9f24fe07e572baacdf8cdea24fc79ccbf0979e9371ac23c6d68de36;
  localparam logic [255:0] K08 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, rdy;
  logic         start4, start8;
  logic [127:0] lk4;
  logic [255:0] lk8;
  logic         busy4, ov4, done4, busy8, ov8, done8;
  logic [127:0] rk4, rk8;
  logic [3:0]   ri4, ri8;

  key_expansion_inv #(.nk(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .last_key(lk4), .busy(busy4),
    .out_valid(ov4), .out_ready(rdy), .round_key(rk4), .round_idx(ri4), .done(done4)
  );

  key_expansion_inv #(.nk(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .last_key(lk8), .busy(busy8),
    .out_valid(ov8), .out_ready(rdy), .round_key(rk8), .round_idx(ri8), .done(done8)
  );

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  typedef struct {
    int           nk;
    logic [255:0] lk;
    logic [255:0] k0;
    logic [3:0]   idx;
    logic [127:0] key;
  } vec_t;

  exp_t       sb[$];
  vec_t       tbl[9];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       done_exp = 1'b0;
  logic [7:0] sbx[256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sbx[t[31:24]], sbx[t[23:16]], sbx[t[15:8]], sbx[t[7:0]]};
  endfunction

  // S-box from exp/log tables over generator 3.
  task automatic build_sbox();
    logic [7:0] ex[256];
    int         lg[256];
    logic [7:0] x, inv;
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = x;
      lg[x] = i;
      x = x ^ xt(x);
    end
    sbx[0] = 8'h63;
    for (int a = 1; a < 256; a++) begin
      inv = ex[(255 - lg[a]) % 255];
      sbx[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  // Forward key expansion from the cipher key; pushes round keys Nr..0.
  task automatic push_model(input int nk, input logic [255:0] k0);
    logic [31:0] w[60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nw;
    nw = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) w[i] = k0[32*(nk-i)-1 -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int k = 1; k < i / nk; k++) rc = xt(rc);
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = nk + 6; r >= 0; r--) begin
      sb.push_back('{idx: 4'(r), key: {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]}});
    end
  endtask

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic sb_check(input logic [127:0] k, input logic [3:0] r, input logic hs,
                          output logic fin0);
    fin0 = 1'b0;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL sb_unexpected: got idx %0d key %h, want nothing", r, k);
    end else begin
      if (k !== sb[0].key || r !== sb[0].idx) begin
        n_bad++;
        $display("FAIL sb_key: got idx %0d key %h, want idx %0d key %h",
                 r, k, sb[0].idx, sb[0].key);
      end
      if (hs) begin
        fin0 = (sb[0].idx == 4'd0);
        void'(sb.pop_front());
      end
    end
  endtask

  // Scoreboard monitor: every presented key must match the queue head; done follows idx 0.
  always @(negedge clk) begin
    logic fin0;
    fin0 = 1'b0;
    if (reset) begin
      if (ov4) sb_check(rk4, ri4, rdy, fin0);
      if (ov8) sb_check(rk8, ri8, rdy, fin0);
      if (done_exp) begin
        chk("done_pulse", 256'(done4 | done8), 256'd1);
      end else if (done4 | done8) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_spurious: got 1 want 0");
      end
      done_exp = fin0;
    end
  end

  function automatic logic get_valid(input int nk);
    return (nk == 4) ? ov4 : ov8;
  endfunction
  function automatic logic get_done(input int nk);
    return (nk == 4) ? done4 : done8;
  endfunction
  function automatic logic [3:0] get_idx(input int nk);
    return (nk == 4) ? ri4 : ri8;
  endfunction
  function automatic logic [127:0] get_key(input int nk);
    return (nk == 4) ? rk4 : rk8;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int nk, input logic [255:0] lk, input logic [255:0] k0,
                          input bit push);
    if (push) push_model(nk, k0);
    if (nk == 4) begin
      start4 = 1'b1;
      lk4    = lk[127:0];
    end else begin
      start8 = 1'b1;
      lk8    = lk;
    end
    step();
    start4 = 1'b0;
    start8 = 1'b0;
    lk4    = {4{$urandom()}};
    lk8    = {8{$urandom()}};
  endtask

  task automatic wait_key(input int nk, input logic [3:0] idx);
    int n;
    n = 0;
    while (!(get_valid(nk) && get_idx(nk) == idx) && n < 150) begin
      step();
      n++;
    end
    chk("reach_idx", {get_valid(nk), get_idx(nk)}, {1'b1, idx});
  endtask

  task automatic wait_done(input int nk, input bit rnd);
    int n;
    n = 0;
    while (!get_done(nk) && n < 600) begin
      if (rnd) rdy = 1'($urandom_range(0, 1));
      if (rnd && n == 20) start4 = 1'b1;
      step();
      start4 = 1'b0;
      n++;
    end
    rdy = 1'b1;
    chk("done_reached", 256'(get_done(nk)), 256'd1);
    chk("sb_drained", 256'(sb.size()), 256'd0);
  endtask

  initial begin
    int n;
    build_sbox();
    tbl[0] = '{4, V1, K0A, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
    tbl[1] = '{4, V1, K0A, 4'd9,  128'h549932d1f08557681093ed9cbe2c974e};
    tbl[2] = '{4, V1, K0A, 4'd0,  128'h000102030405060708090a0b0c0d0e0f};
    tbl[3] = '{4, V2, K0B, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    tbl[4] = '{4, V2, K0B, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    tbl[5] = '{8, V8, K08, 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
    tbl[6] = '{8, V8, K08, 4'd13, 128'h4e5a6699a9f24fe07e572baacdf8cdea};
    tbl[7] = '{8, V8, K08, 4'd1,  128'h101112131415161718191a1b1c1d1e1f};
    tbl[8] = '{8, V8, K08, 4'd0,  128'h000102030405060708090a0b0c0d0e0f};

    reset  = 1'b0;
    rdy    = 1'b1;
    start4 = 1'b0;
    start8 = 1'b0;
    lk4    = '0;
    lk8    = '0;
    repeat (3) step();
    chk("reset_state4", 256'({busy4, ov4, done4, ri4, rk4}), 256'd0);
    chk("reset_state8", 256'({busy8, ov8, done8, ri8, rk8}), 256'd0);
    reset = 1'b1;
    step();

    // Spec vectors, each a full run with out_ready held high.
    for (int e = 0; e < 9; e++) begin
      do_start(tbl[e].nk, tbl[e].lk, tbl[e].k0, 1'b1);
      wait_key(tbl[e].nk, tbl[e].idx);
      chk("table_key", 256'(get_key(tbl[e].nk)), 256'(tbl[e].key));
      wait_done(tbl[e].nk, 1'b0);
      step();
    end

    // Latency: first key 4 cycles after start, done 55 cycles after start.
    do_start(4, V1, K0A, 1'b1);
    n = 0;
    while (!ov4 && n < 20) begin
      step();
      n++;
    end
    chk("first_valid_latency", 256'(n), 256'd4);
    while (!done4 && n < 100) begin
      step();
      n++;
    end
    chk("done_latency", 256'(n), 256'd55);
    step();
    chk("done_one_cycle", 256'({done4, busy4}), 256'd0);
    chk("sb_drained_lat", 256'(sb.size()), 256'd0);

    // Backpressure at idx 9 with a start while busy, then random out_ready.
    do_start(4, V1, K0A, 1'b1);
    wait_key(4, 4'd9);
    rdy = 1'b0;
    step();
    do_start(4, V2, K0B, 1'b0);
    repeat (5) step();
    chk("bp_hold", 256'({ov4, ri4, rk4}), 256'({1'b1, 4'd9, 128'h549932d1f08557681093ed9cbe2c974e}));
    chk("busy_held", 256'(busy4), 256'd1);
    wait_done(4, 1'b1);
    step();

    // Reset during assembly of idx 5, then a fresh full run.
    do_start(4, V2, K0B, 1'b1);
    wait_key(4, 4'd6);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("reset_async", 256'({busy4, ov4, done4, ri4, rk4}), 256'd0);
    sb.delete();
    done_exp = 1'b0;
    step();
    chk("reset_held", 256'({busy4, ov4, done4, ri4, rk4}), 256'd0);
    reset = 1'b1;
    step();
    do_start(4, V1, K0A, 1'b1);
    wait_key(4, 4'd10);
    wait_done(4, 1'b0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
